// File: rtl/temporal_edge_encoder.sv
// Binary-to-race-logic edge encoder: SET pulse, then a GAMMA-cycle window.
// Define TEMPORAL_EDGE_PULSE_EN for one-cycle pulse code instead of rising edges.
module temporal_edge_encoder #(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int GAMMA = 16
) (
  input  logic           aclk,
  input  logic           grst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_null,
  output logic           set,
  output logic [N-1:0]   edge_out,
  output logic           busy,
  output logic           gamma_done
);

  localparam int CW = (GAMMA > 1) ? $clog2(GAMMA) : 1;

  if (GAMMA < (1 << W)) begin : g_gamma_chk
    $error("GAMMA must be at least 2**W");
  end

  typedef enum logic [1:0] {
    IDLE,
    SET,
    RUN
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [N*W-1:0] data_q;
  logic [N-1:0]   null_q;
  logic [N-1:0]   hit_d;
  logic           rdy_q;
  logic           set_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   edge_q;

  // Look one count ahead so the edge register lands in the matching cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
    end
    hit_d = '0;
    for (int i = 0; i < N; i++) begin
      hit_d[i] = ~null_q[i] && (cnt_d == CW'(data_q[i*W +: W]));
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      null_q  <= '0;
      rdy_q   <= 1'b1;
      set_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      edge_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && rdy_q) begin
            state_q <= SET;
            data_q  <= in_data;
            null_q  <= in_null;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            set_q   <= 1'b1;
            busy_q  <= 1'b1;
            edge_q  <= '0;
          end
        end
        SET: begin
          state_q <= RUN;
          cnt_q   <= '0;
          set_q   <= 1'b0;
          done_q  <= 1'b0;
          edge_q  <= hit_d;
        end
        RUN: begin
          if (cnt_q == CW'(GAMMA - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TEMPORAL_EDGE_PULSE_EN
            edge_q  <= '0;
`endif
          end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == CW'(GAMMA - 1));
`ifdef TEMPORAL_EDGE_PULSE_EN
            edge_q <= hit_d;
`else
            edge_q <= edge_q | hit_d;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reset must pull ready low immediately, not at the next clock.
  assign in_ready   = rdy_q & ~grst;
  assign set        = set_q;
  assign edge_out   = edge_q;
  assign busy       = busy_q;
  assign gamma_done = done_q;

endmodule
